div_ctrl: RTL

Responder side of the start/halt program handshake. It sits inside `TopLevel` next to `data_mem1`. On a start pulse it waits for `start` to fall, then reads its operands from data memory and runs a bit-serial restoring divide. It writes the rounded quotient back to memory and raises `halt`. It implements program 1 (16-bit reciprocal) and program 2 (16/8 fixed-point divide) with half-LSB upward rounding.

---
 rtl/div_pkg.sv | 93 +++++++++
 rtl/div_iter.sv | 55 +++++
 rtl/div_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared types and constants for the start/halt divide responder (div_ctrl)
// and its bit-serial core (div_iter).
//
// Contents:
//   state_e            FSM states of div_ctrl
//   mode_e             program select (1/x reciprocal or a/b fixed-point)
//   *_ADDR             data memory byte addresses of operands and results
//   ITER_P1 / ITER_P2  quotient bits produced per program (17 / 25)
//   RES_W_P1 / _P2     stored result widths (16 / 24)
//   load_addr/store_addr/store_byte  byte sequencing helpers
//
// Configuration macro: DIV0_SAT_EN
//   Supplied by the build. The default build defines it, so a zero divisor
//   saturates to an all-ones result. Building without it runs the full
//   divide on a zero divisor (stored result then wraps to zero).
// -----------------------------------------------------------------------------
package div_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_LOAD  = 3'd2,
    ST_DIV   = 3'd3,
    ST_ROUND = 3'd4,
    ST_STORE = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

  typedef enum logic {
    MODE_RECIP = 1'b0,  // program 1: 2^63 / divisor16
    MODE_FRAC  = 1'b1   // program 2: (dividend16 << 48) / divisor8
  } mode_e;

  // Operand / result byte addresses (MSB at the lowest address).
  localparam logic [7:0] P1_DIVISOR_ADDR  = 8'd8;
  localparam logic [7:0] P1_RESULT_ADDR   = 8'd10;
  localparam logic [7:0] P2_DIVIDEND_ADDR = 8'd0;
  localparam logic [7:0] P2_DIVISOR_ADDR  = 8'd2;
  localparam logic [7:0] P2_RESULT_ADDR   = 8'd4;

  // Quotient bits generated: 63..47 for program 1, 63..39 for program 2.
  localparam int ITER_P1 = 17;
  localparam int ITER_P2 = 25;

  localparam int RES_W_P1 = 16;
  localparam int RES_W_P2 = 24;

  localparam int LOAD_BYTES_P1  = 2;
  localparam int LOAD_BYTES_P2  = 3;
  localparam int STORE_BYTES_P1 = RES_W_P1 / 8;
  localparam int STORE_BYTES_P2 = RES_W_P2 / 8;

  // Address of the idx-th operand byte read during LOAD.
  function automatic logic [7:0] load_addr(input mode_e m, input logic [1:0] idx);
    logic [7:0] a;
    a = 8'd0;
    if (m == MODE_RECIP) begin
      a = P1_DIVISOR_ADDR + 8'(idx);
    end else begin
      case (idx)
        2'd0:    a = P2_DIVIDEND_ADDR;
        2'd1:    a = P2_DIVIDEND_ADDR + 8'd1;
        default: a = P2_DIVISOR_ADDR;
      endcase
    end
    return a;
  endfunction

  // Address of the idx-th result byte written during STORE.
  function automatic logic [7:0] store_addr(input mode_e m, input logic [1:0] idx);
    return ((m == MODE_RECIP) ? P1_RESULT_ADDR : P2_RESULT_ADDR) + 8'(idx);
  endfunction

  // Result byte for write idx, most significant byte first.
  function automatic logic [7:0] store_byte(input mode_e m, input logic [1:0] idx,
                                            input logic [23:0] res);
    logic [7:0] b;
    b = 8'd0;
    if (m == MODE_RECIP) begin
      b = (idx == 2'd0) ? res[15:8] : res[7:0];
    end else begin
      case (idx)
        2'd0:    b = res[23:16];
        2'd1:    b = res[15:8];
        default: b = res[7:0];
      endcase
    end
    return b;
  endfunction

endpackage

// File: rtl/div_iter.sv
// -----------------------------------------------------------------------------
// div_iter
// Bit-serial restoring division core. Each step shifts the next numerator bit
// into the remainder, subtracts the divisor when it fits and shifts the
// resulting quotient bit into the quotient register.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   init        clear remainder and quotient (has priority over step)
//   step        perform one restoring iteration
//   num_bit     next numerator bit, most significant first
//   divisor     16-bit divisor (zero-extended by the caller for 8-bit use)
//   quotient    25-bit quotient shift register, newest bit in bit 0
// -----------------------------------------------------------------------------
module div_iter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        step,
  input  logic        num_bit,
  input  logic [15:0] divisor,
  output logic [24:0] quotient
);

  logic [16:0] rem_q;
  logic [24:0] quo_q;
  logic [17:0] shifted;
  logic        fits;

  // The remainder is always below the divisor before a shift, so 17 bits
  // hold the shifted value; the extra compare bit keeps the math exact.
  assign shifted = {rem_q, num_bit};
  assign fits    = (shifted >= {2'b00, divisor});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
    end else if (init) begin
      rem_q <= '0;
      quo_q <= '0;
    end else if (step) begin
      if (fits) begin
        rem_q <= 17'(shifted - {2'b00, divisor});
        quo_q <= {quo_q[23:0], 1'b1};
      end else begin
        rem_q <= 17'(shifted);
        quo_q <= {quo_q[23:0], 1'b0};
      end
    end
  end

  assign quotient = quo_q;

endmodule

// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl
// Responder for the start/halt program handshake. Loads operands from data
// memory, runs a bit-serial restoring divide (div_iter), rounds the quotient
// half-LSB upward and writes the result back, then raises halt.
//   program 1 (mode=0): result16 = round(2^63 / d16), d16 @8/@9, result @10/@11
//   program 2 (mode=1): result24 = round((a16<<48) / d8), a16 @0/@1, d8 @2,
//                       result @4/@5/@6
//
// Ports:
//   CLK, RST_N   clock, asynchronous active-low reset
//   start        request: high while operands are set up, falling launches
//   mode         program select, sampled on the launch edge
//   halt         registered done flag, held until start rises again
//   mem_addr     data memory byte address
//   mem_wr_en    write strobe (only asserted while storing the result)
//   mem_wr_data  write byte
//   mem_rd_data  combinational read data for mem_addr
//   dbg_state    current FSM state (div_pkg::state_e encoding)
//
// Configuration macro: DIV0_SAT_EN (zero divisor -> all-ones result, skipping
// DIV and ROUND). Without it a zero divisor runs the full divide.
// -----------------------------------------------------------------------------
module div_ctrl
  import div_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       start,
  input  logic       mode,
  output logic       halt,
  output logic [7:0] mem_addr,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_data,
  input  logic [7:0] mem_rd_data,
  output logic [2:0] dbg_state
);

  // Handshake: start=1 in any state aborts/holds the block in ARMED with
  // halt low (no further writes are issued). The first edge that sees start=0
  // in ARMED launches the program and captures mode. halt rises on the edge
  // that completes the last result write and stays high until start rises.
  // IDLE (after reset) ignores start=0 until start has been seen high once.

  state_e      state_q, state_d;
  mode_e       mode_q;
  logic [4:0]  cnt_q;
  logic [15:0] dividend_q;
  logic [15:0] divisor_q;
  logic [23:0] result_q;
  logic [23:0] rounded;
  logic [24:0] quo;
  logic        load_last, div_last, store_last;
  logic        sat_zero;
  logic        num_bit;
  logic        iter_init, iter_step;

  // ---------------------------------------------------------------------------
  // Sequencing conditions
  // ---------------------------------------------------------------------------
  assign load_last  = (mode_q == MODE_RECIP) ? (cnt_q == 5'(LOAD_BYTES_P1 - 1))
                                             : (cnt_q == 5'(LOAD_BYTES_P2 - 1));
  assign div_last   = (mode_q == MODE_RECIP) ? (cnt_q == 5'(ITER_P1 - 1))
                                             : (cnt_q == 5'(ITER_P2 - 1));
  assign store_last = (mode_q == MODE_RECIP) ? (cnt_q == 5'(STORE_BYTES_P1 - 1))
                                             : (cnt_q == 5'(STORE_BYTES_P2 - 1));

  // Zero-divisor test happens on the last LOAD edge, so the byte arriving on
  // the bus in that cycle is part of the divisor being checked.
`ifdef DIV0_SAT_EN
  assign sat_zero = (mode_q == MODE_RECIP) ? ({divisor_q[15:8], mem_rd_data} == 16'd0)
                                           : (mem_rd_data == 8'd0);
`else
  assign sat_zero = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_ARMED;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_IDLE;
        ST_ARMED: state_d = ST_LOAD;
        ST_LOAD:  if (load_last) state_d = sat_zero ? ST_STORE : ST_DIV;
        ST_DIV:   if (div_last) state_d = ST_ROUND;
        ST_ROUND: state_d = ST_STORE;
        ST_STORE: if (store_last) state_d = ST_DONE;
        ST_DONE:  state_d = ST_DONE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (memory bus decoded from state and byte counter)
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_addr    = 8'd0;
    mem_wr_en   = 1'b0;
    mem_wr_data = 8'd0;
    case (state_q)
      ST_LOAD: begin
        mem_addr = load_addr(mode_q, cnt_q[1:0]);
      end
      ST_STORE: begin
        mem_addr    = store_addr(mode_q, cnt_q[1:0]);
        mem_wr_en   = 1'b1;
        mem_wr_data = store_byte(mode_q, cnt_q[1:0], result_q);
      end
      default: ;
    endcase
  end

  assign dbg_state = state_q;

  // ---------------------------------------------------------------------------
  // Numerator bit stream: program 1 is a single 1 at bit 63, program 2 is the
  // dividend in bits 63..48 followed by zeros.
  // ---------------------------------------------------------------------------
  always_comb begin
    num_bit = 1'b0;
    if (mode_q == MODE_RECIP) begin
      num_bit = (cnt_q == 5'd0);
    end else if (cnt_q < 5'd16) begin
      num_bit = dividend_q[4'd15 - cnt_q[3:0]];
    end
  end

  assign iter_init = (state_q == ST_LOAD);
  assign iter_step = (state_q == ST_DIV);

  div_iter u_iter (
    .clk      (CLK),
    .rst_n    (RST_N),
    .init     (iter_init),
    .step     (iter_step),
    .num_bit  (num_bit),
    .divisor  (divisor_q),
    .quotient (quo)
  );

  // Lowest quotient bit is the round bit; the sum wraps at the result width.
  always_comb begin
    rounded = 24'd0;
    if (mode_q == MODE_RECIP) begin
      rounded = {8'd0, quo[16:1] + {15'd0, quo[0]}};
    end else begin
      rounded = quo[24:1] + {23'd0, quo[0]};
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers, byte counter and registered halt
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      halt       <= 1'b0;
      cnt_q      <= '0;
      mode_q     <= MODE_RECIP;
      dividend_q <= '0;
      divisor_q  <= '0;
      result_q   <= '0;
    end else begin
      halt  <= (state_d == ST_DONE);
      // Counter restarts on every state change, so it indexes bytes within
      // LOAD/STORE and iterations within DIV.
      cnt_q <= (state_d != state_q) ? 5'd0 : cnt_q + 5'd1;

      if (state_q == ST_ARMED && state_d == ST_LOAD) begin
        mode_q <= mode_e'(mode);
      end

      if (state_q == ST_LOAD) begin
        if (mode_q == MODE_RECIP) begin
          if (cnt_q == 5'd0) divisor_q[15:8] <= mem_rd_data;
          else               divisor_q[7:0]  <= mem_rd_data;
        end else begin
          case (cnt_q[1:0])
            2'd0:    dividend_q[15:8] <= mem_rd_data;
            2'd1:    dividend_q[7:0]  <= mem_rd_data;
            default: divisor_q        <= {8'd0, mem_rd_data};
          endcase
        end
        if (load_last && sat_zero) begin
          result_q <= (mode_q == MODE_RECIP) ? 24'h00FFFF : 24'hFFFFFF;
        end
      end

      if (state_q == ST_ROUND) begin
        result_q <= rounded;
      end
    end
  end

endmodule
